// File: rtl/field_normalizer.sv
// field_normalizer: turns raw Q16.16 velocity vectors into {xn, yn, mag} field words
module field_normalizer #(
   parameter int FIELD_WIDTH  = 8,
   parameter int FIELD_HEIGHT = 6,
   parameter int FIELD_SIZE   = FIELD_WIDTH * FIELD_HEIGHT,
   parameter int FIELD_ADDRW  = $clog2(FIELD_SIZE),
   parameter int FIELD_DATAW  = 96
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [FIELD_ADDRW-1:0] in_addr,
   input  logic [31:0]            in_vx,
   input  logic [31:0]            in_vy,
   output logic                   field_we,
   output logic [FIELD_ADDRW-1:0] field_addr_write,
   output logic [FIELD_DATAW-1:0] field_data_in,
   output logic                   start_draw,
   output logic                   busy
);
   typedef enum logic [2:0] {IDLE, SQUARE, SQRT, DIV, WRITE, DONE} state_t;

   localparam logic [FIELD_ADDRW:0]   LIMIT = (FIELD_ADDRW + 1)'(FIELD_SIZE);
   localparam logic [FIELD_ADDRW-1:0] LAST  = FIELD_ADDRW'(FIELD_SIZE - 1);

   state_t                 state_q, state_d;
   logic [FIELD_ADDRW-1:0] addr_q, addr_d, waddr_q, waddr_d;
   logic [FIELD_DATAW-1:0] wdata_q, wdata_d;
   logic                   sx_q, sx_d, sy_q, sy_d, we_q, we_d;
   logic [31:0]            ax_q, ax_d, ay_q, ay_d, root_q, root_d;
   logic [31:0]            rx_q, rx_d, ry_q, ry_d, qx_q, qx_d, qy_q, qy_d;
   logic [63:0]            rad_q, rad_d;
   logic [35:0]            rem_q, rem_d, rem_t, trial;
   logic [32:0]            rx_t, ry_t, mag33;
   logic [4:0]             cnt_q, cnt_d;
   logic                   sq_ge, dx_ge, dy_ge, in_range;

   // The dividend's top 16 bits seed the remainder; the 32 remaining bits
   // are shifted in MSB first out of ax/ay, since |v| <= mag keeps the
   // quotient below 2^32.
   assign rem_t    = (rem_q << 2) | {34'b0, rad_q[63:62]};
   assign trial    = {2'b0, root_q, 2'b01};
   assign sq_ge    = rem_t >= trial;
   assign mag33    = {1'b0, root_q};
   assign rx_t     = {rx_q, ax_q[31]};
   assign ry_t     = {ry_q, ay_q[31]};
   assign dx_ge    = rx_t >= mag33;
   assign dy_ge    = ry_t >= mag33;
   assign in_range = {1'b0, addr_q} < LIMIT;

   assign in_ready         = state_q == IDLE;
   assign busy             = state_q != IDLE;
   assign start_draw       = state_q == DONE;
   assign field_we         = we_q;
   assign field_addr_write = waddr_q;
   assign field_data_in    = wdata_q;

   // Next-state, square/sqrt/divide datapath and write-port capture
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      sx_d    = sx_q;
      sy_d    = sy_q;
      ax_d    = ax_q;
      ay_d    = ay_q;
      rad_d   = rad_q;
      rem_d   = rem_q;
      root_d  = root_q;
      rx_d    = rx_q;
      ry_d    = ry_q;
      qx_d    = qx_q;
      qy_d    = qy_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: if (in_valid) begin
            state_d = SQUARE;
            addr_d  = in_addr;
            sx_d    = in_vx[31];
            sy_d    = in_vy[31];
            ax_d    = in_vx[31] ? -in_vx : in_vx;
            ay_d    = in_vy[31] ? -in_vy : in_vy;
         end
         SQUARE: begin
            rad_d   = {32'b0, ax_q} * {32'b0, ax_q} + {32'b0, ay_q} * {32'b0, ay_q};
            rem_d   = '0;
            root_d  = '0;
            cnt_d   = '0;
            state_d = SQRT;
         end
         SQRT: begin
            rad_d  = rad_q << 2;
            rem_d  = sq_ge ? rem_t - trial : rem_t;
            root_d = {root_q[30:0], sq_ge};
            cnt_d  = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
               rx_d    = {16'b0, ax_q[31:16]};
               ry_d    = {16'b0, ay_q[31:16]};
               ax_d    = {ax_q[15:0], 16'b0};
               ay_d    = {ay_q[15:0], 16'b0};
               qx_d    = '0;
               qy_d    = '0;
               state_d = (root_d == 32'd0) ? WRITE : DIV;
            end
         end
         DIV: begin
            ax_d  = ax_q << 1;
            ay_d  = ay_q << 1;
            rx_d  = dx_ge ? 32'(rx_t - mag33) : rx_t[31:0];
            ry_d  = dy_ge ? 32'(ry_t - mag33) : ry_t[31:0];
            qx_d  = {qx_q[30:0], dx_ge};
            qy_d  = {qy_q[30:0], dy_ge};
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31)
               state_d = WRITE;
         end
         WRITE:   state_d = (in_range && addr_q == LAST) ? DONE : IDLE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      we_d    = state_d == WRITE && in_range;
      waddr_d = we_d ? addr_q : waddr_q;
      wdata_d = we_d ? {sx_q ? -qx_d : qx_d, sy_q ? -qy_d : qy_d, root_d} : wdata_q;
   end

   // State and datapath registers; reset aborts any vector in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         sx_q    <= 1'b0;
         sy_q    <= 1'b0;
         ax_q    <= '0;
         ay_q    <= '0;
         rad_q   <= '0;
         rem_q   <= '0;
         root_q  <= '0;
         rx_q    <= '0;
         ry_q    <= '0;
         qx_q    <= '0;
         qy_q    <= '0;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         sx_q    <= sx_d;
         sy_q    <= sy_d;
         ax_q    <= ax_d;
         ay_q    <= ay_d;
         rad_q   <= rad_d;
         rem_q   <= rem_d;
         root_q  <= root_d;
         rx_q    <= rx_d;
         ry_q    <= ry_d;
         qx_q    <= qx_d;
         qy_q    <= qy_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
      end
   end
endmodule

// File: tb/tb_field_normalizer.sv
// tb_field_normalizer: directed vector table plus reset and streaming sequences
module tb_field_normalizer;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [5:0]  in_addr = '0;
   logic [31:0] in_vx = '0;
   logic [31:0] in_vy = '0;
   logic        field_we;
   logic [5:0]  field_addr_write;
   logic [95:0] field_data_in;
   logic        start_draw;
   logic        busy;

   int pass_cnt = 0;
   int total_cnt = 0;

   field_normalizer dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_addr(in_addr), .in_vx(in_vx), .in_vy(in_vy), .field_we(field_we),
      .field_addr_write(field_addr_write), .field_data_in(field_data_in),
      .start_draw(start_draw), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [5:0]  a;
      logic [31:0] vx;
      logic [31:0] vy;
      int          we_c;
      int          rdy_c;
      int          sd_c;
      logic [95:0] d;
   } vec_t;

   vec_t tv[9];

   task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Cycle c is counted from the handshake edge closing cycle 0
   task automatic run_vec(input logic [5:0] a, input logic [31:0] vx, input logic [31:0] vy,
                          output int we_c, output int rdy_c, output int sd_c, output int nwe,
                          output logic [5:0] wa, output logic [95:0] wd);
      in_valid = 1'b1;
      in_addr  = a;
      in_vx    = vx;
      in_vy    = vy;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_addr  = ~a;
      in_vx    = ~vx;
      in_vy    = vy ^ 32'h5A5A_A5A5;
      we_c = -1; rdy_c = -1; sd_c = -1; nwe = 0; wa = '0; wd = '0;
      for (int c = 1; c <= 200 && rdy_c < 0; c++) begin
         if (field_we) begin
            nwe++;
            if (we_c < 0) we_c = c;
            wa = field_addr_write;
            wd = field_data_in;
         end
         if (start_draw && sd_c < 0) sd_c = c;
         if (in_ready) rdy_c = c;
         if (rdy_c < 0) begin @(posedge clk); #1; end
      end
   endtask

   initial begin
      int we_c, rdy_c, sd_c, nwe, cnt, nacc, nwr, nsd, we47, sdc, last_acc, errs, sd_ok;
      logic [5:0]  wa;
      logic [95:0] wd;
      tv[0] = '{6'd0,  32'h001E_0000, 32'h0028_0000, 66, 67, -1, {32'd39321, 32'd52428, 32'd3276800}};
      tv[1] = '{6'd1,  32'hFFE2_0000, 32'h0028_0000, 66, 67, -1, {32'hFFFF6667, 32'd52428, 32'd3276800}};
      tv[2] = '{6'd2,  32'h0000_0000, 32'h0000_0000, 34, 35, -1, 96'd0};
      tv[3] = '{6'd3,  32'h0001_0000, 32'h0000_0000, 66, 67, -1, {32'd65536, 32'd0, 32'd65536}};
      tv[4] = '{6'd4,  32'h0000_0000, 32'hFFFD_0000, 66, 67, -1, {32'd0, 32'hFFFF0000, 32'd196608}};
      tv[5] = '{6'd48, 32'h001E_0000, 32'h0028_0000, -1, 67, -1, 96'd0};
      tv[6] = '{6'd5,  32'h8000_0000, 32'h8000_0000, 66, 67, -1, {32'hFFFF4AFC, 32'hFFFF4AFC, 32'hB504F333}};
      tv[7] = '{6'd6,  32'h0000_0001, 32'h0000_0000, 66, 67, -1, {32'd65536, 32'd0, 32'd1}};
      tv[8] = '{6'd47, 32'h0001_0000, 32'h0000_0000, 66, 68, 67, {32'd65536, 32'd0, 32'd65536}};

      repeat (3) @(posedge clk);
      #1;
      chk("reset in_ready", 96'(in_ready), 96'd1);
      chk("reset field_we", 96'(field_we), 96'd0);
      chk("reset addr", 96'(field_addr_write), 96'd0);
      chk("reset data", field_data_in, 96'd0);
      chk("reset start_draw", 96'(start_draw), 96'd0);
      chk("reset busy", 96'(busy), 96'd0);
      rst = 1'b0;

      // Abort mid-SQRT with an asynchronous reset between edges
      @(posedge clk); #1;
      in_valid = 1'b1; in_addr = 6'd0; in_vx = 32'h001E_0000; in_vy = 32'h0028_0000;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      chk("busy before abort", 96'(busy), 96'd1);
      #2 rst = 1'b1;
      #1;
      chk("abort in_ready", 96'(in_ready), 96'd1);
      chk("abort busy", 96'(busy), 96'd0);
      chk("abort field_we", 96'(field_we), 96'd0);
      chk("abort start_draw", 96'(start_draw), 96'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      cnt = 0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         if (field_we || start_draw) cnt++;
      end
      chk("abort no write", 96'(cnt), 96'd0);
      chk("abort idle ready", 96'(in_ready), 96'd1);

      for (int i = 0; i < 9; i++) begin
         run_vec(tv[i].a, tv[i].vx, tv[i].vy, we_c, rdy_c, sd_c, nwe, wa, wd);
         chk($sformatf("v%0d we cycle", i), 96'(we_c), 96'(tv[i].we_c));
         chk($sformatf("v%0d we count", i), 96'(nwe), (tv[i].we_c < 0) ? 96'd0 : 96'd1);
         chk($sformatf("v%0d ready cycle", i), 96'(rdy_c), 96'(tv[i].rdy_c));
         chk($sformatf("v%0d start_draw cycle", i), 96'(sd_c), 96'(tv[i].sd_c));
         if (tv[i].we_c >= 0) begin
            chk($sformatf("v%0d addr", i), 96'(wa), 96'(tv[i].a));
            chk($sformatf("v%0d data", i), wd, tv[i].d);
         end
         @(posedge clk); #1;
      end

      // Stream the whole frame with in_valid held high
      in_valid = 1'b1; in_addr = 6'd0; in_vx = 32'h0003_0000; in_vy = 32'h0004_0000;
      nacc = 0; nwr = 0; nsd = 0; we47 = -1; sdc = -1; last_acc = -1; errs = 0; sd_ok = 0;
      for (int c = 0; c < 4000 && !(nacc == 48 && in_ready && c > last_acc + 2); c++) begin
         if (field_we) begin
            if (field_addr_write != 6'(nwr)) errs++;
            if (field_data_in != {32'd39321, 32'd52428, 32'd327680}) errs++;
            if (field_addr_write == 6'd47) we47 = c;
            nwr++;
         end
         if (start_draw) begin
            nsd++;
            sdc = c;
            sd_ok = (busy && !in_ready) ? 1 : 0;
         end
         if (in_ready && in_valid) begin
            if (last_acc >= 0 && c - last_acc != 67) errs++;
            last_acc = c;
            nacc++;
            @(posedge clk); #1;
            if (nacc < 48) in_addr = 6'(nacc);
            else in_valid = 1'b0;
         end else begin
            @(posedge clk); #1;
         end
      end
      in_valid = 1'b0;
      chk("stream accepts", 96'(nacc), 96'd48);
      chk("stream writes", 96'(nwr), 96'd48);
      chk("stream order/data/spacing errors", 96'(errs), 96'd0);
      chk("stream start_draw count", 96'(nsd), 96'd1);
      chk("stream start_draw after last write", 96'(sdc - we47), 96'd1);
      chk("stream DONE busy/not ready", 96'(sd_ok), 96'd1);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
